// File: rtl/cache_axi_arbiter.sv
// Arbitrates icache/dcache line refills and dcache victim writebacks onto one AXI3 master port.
// Optional macro AXI_WRITE_BUFFER_EN: capture victim line on acceptance and complete writeback early.
module cache_axi_arbiter #(
  parameter int LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ic_req,
  input  logic [31:0]              ic_addr,
  output logic                     ic_refresh,
  output logic [LINE_WORDS*32-1:0] ic_line,
  input  logic                     dc_rd_req,
  input  logic [31:0]              dc_rd_addr,
  output logic                     dc_refresh,
  output logic [LINE_WORDS*32-1:0] dc_line,
  input  logic                     dc_wr_req,
  input  logic [31:0]              dc_wr_addr,
  input  logic [LINE_WORDS*32-1:0] dc_wr_line,
  output logic                     dc_wr_done,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [3:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [3:0]               awid,
  output logic [31:0]              awaddr,
  output logic [3:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic [1:0]               awlock,
  output logic [3:0]               awcache,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [3:0]               wid,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [3:0]               bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int LB = LINE_WORDS * 32;
  localparam int BW = $clog2(LINE_WORDS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_e;

  r_state_e       r_state_q, r_state_d;
  logic           r_is_dc_q, r_is_dc_d;
  logic [31:0]    r_addr_q, r_addr_d;
  logic [BW-1:0]  r_beat_q, r_beat_d;
  logic [LB-1:0]  stage_q, stage_d;
  logic [LB-1:0]  ic_line_q, ic_line_d;
  logic [LB-1:0]  dc_line_q, dc_line_d;

  w_state_e       w_state_q, w_state_d;
  logic [31:0]    w_addr_q, w_addr_d;
  logic [BW-1:0]  w_beat_q, w_beat_d;
  logic           wr_done_q, wr_done_d;
  logic [LB-1:0]  wr_src;
  logic           rd_hazard;
  logic           unused_axi;

  assign unused_axi = ^{rid, rresp, bid, bresp};

`ifdef AXI_WRITE_BUFFER_EN
  logic [LB-1:0]  wr_buf_q, wr_buf_d;
  assign wr_src = wr_buf_q;
`else
  assign wr_src = dc_wr_line;
`endif

  // A refill must not read a line that a writeback is about to overwrite in memory.
  assign rd_hazard =
      ((w_state_q != W_IDLE) && ((dc_rd_addr & LINE_MASK) == w_addr_q)) ||
      ((w_state_q == W_IDLE) && dc_wr_req && !wr_done_q &&
       ((dc_rd_addr & LINE_MASK) == (dc_wr_addr & LINE_MASK)));

  always_comb begin
    r_state_d  = r_state_q;
    r_is_dc_d  = r_is_dc_q;
    r_addr_d   = r_addr_q;
    r_beat_d   = r_beat_q;
    stage_d    = stage_q;
    ic_line_d  = ic_line_q;
    dc_line_d  = dc_line_q;
    arvalid    = 1'b0;
    rready     = 1'b0;
    ic_refresh = 1'b0;
    dc_refresh = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        r_beat_d = '0;
        if (dc_rd_req) begin
          if (!rd_hazard) begin
            r_is_dc_d = 1'b1;
            r_addr_d  = dc_rd_addr & LINE_MASK;
            r_state_d = R_AR;
          end
        end else if (ic_req) begin
          r_is_dc_d = 1'b0;
          r_addr_d  = ic_addr & LINE_MASK;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          stage_d[r_beat_q*32 +: 32] = rdata;
          r_beat_d = (r_beat_q == LAST_BEAT) ? '0 : r_beat_q + 1'b1;
          if (rlast) begin
            r_state_d = R_DONE;
            if (r_is_dc_q) dc_line_d = stage_d;
            else           ic_line_d = stage_d;
          end
        end
      end
      R_DONE: begin
        ic_refresh = !r_is_dc_q;
        dc_refresh = r_is_dc_q;
        r_state_d  = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_beat_d  = w_beat_q;
    wr_done_d = 1'b0;
`ifdef AXI_WRITE_BUFFER_EN
    wr_buf_d  = wr_buf_q;
`endif
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        w_beat_d = '0;
        // wr_done_q blocks re-accepting a request still held during its done cycle.
        if (dc_wr_req && !wr_done_q) begin
          w_addr_d  = dc_wr_addr & LINE_MASK;
          w_state_d = W_AW;
`ifdef AXI_WRITE_BUFFER_EN
          wr_buf_d  = dc_wr_line;
          wr_done_d = 1'b1;
`endif
        end
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) w_state_d = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (w_beat_q == LAST_BEAT);
        if (wready) begin
          w_beat_d = wlast ? '0 : w_beat_q + 1'b1;
          if (wlast) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          w_state_d = W_IDLE;
`ifndef AXI_WRITE_BUFFER_EN
          wr_done_d = 1'b1;
`endif
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_is_dc_q <= 1'b0;
      r_addr_q  <= '0;
      r_beat_q  <= '0;
      stage_q   <= '0;
      ic_line_q <= '0;
      dc_line_q <= '0;
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_beat_q  <= '0;
      wr_done_q <= 1'b0;
`ifdef AXI_WRITE_BUFFER_EN
      wr_buf_q  <= '0;
`endif
    end else begin
      r_state_q <= r_state_d;
      r_is_dc_q <= r_is_dc_d;
      r_addr_q  <= r_addr_d;
      r_beat_q  <= r_beat_d;
      stage_q   <= stage_d;
      ic_line_q <= ic_line_d;
      dc_line_q <= dc_line_d;
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_beat_q  <= w_beat_d;
      wr_done_q <= wr_done_d;
`ifdef AXI_WRITE_BUFFER_EN
      wr_buf_q  <= wr_buf_d;
`endif
    end
  end

  assign ic_line    = ic_line_q;
  assign dc_line    = dc_line_q;
  assign dc_wr_done = wr_done_q;

  assign arid    = {3'b000, r_is_dc_q};
  assign araddr  = r_addr_q;
  assign arlen   = 4'(LINE_WORDS - 1);
  assign arsize  = 3'd2;
  assign arburst = 2'd1;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = 4'd1;
  assign awaddr  = w_addr_q;
  assign awlen   = 4'(LINE_WORDS - 1);
  assign awsize  = 3'd2;
  assign awburst = 2'd1;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = 4'd1;
  assign wdata   = wr_src[w_beat_q*32 +: 32];
  assign wstrb   = 4'hF;

endmodule
